// File: rtl/aes_decrypt_arbiter.sv
// aes_decrypt_arbiter: round-robin front end sharing one AES decrypt engine between two requesters.
// Define AES_DEC_ARB_TIMEOUT_EN to add an engine watchdog that aborts a job with out_err=1.
module aes_decrypt_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0_valid,
  input  logic [127:0] req0_cipher,
  input  logic [127:0] req0_key10,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [127:0] req1_cipher,
  input  logic [127:0] req1_key10,
  output logic         req1_ready,
  output logic [127:0] eng_cipher_text,
  output logic [127:0] eng_round_key_10,
  output logic         eng_new_en,
  input  logic         eng_ready,
  input  logic [127:0] eng_plain_text,
  output logic         out_valid,
  output logic [127:0] out_data,
  output logic         out_id,
  output logic         out_err,
  input  logic         out_ready
);
  typedef enum logic [1:0] {IDLE, START, BUSY, HOLD} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, id_q, id_d, first_q, first_d, err_q, err_d;
  logic [127:0] cipher_q, cipher_d, key_q, key_d, data_q, data_d;
  logic grant, win, done, tmo;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be positive");
  end

  assign grant = state_q == IDLE && (req0_valid || req1_valid);
  assign win   = req0_valid && req1_valid ? ~last_q : req1_valid;
  // first_q masks a level eng_ready left over from the previous job
  assign done  = state_q == BUSY && !first_q && eng_ready;

`ifdef AES_DEC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = state_q == START ? '0 : state_q == BUSY ? cnt_q + 1'b1 : cnt_q;
  end
  assign tmo = state_q == BUSY && cnt_d == CW'(TIMEOUT_CYCLES);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      first_q  <= 1'b0;
      err_q    <= 1'b0;
      cipher_q <= '0;
      key_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      first_q  <= first_d;
      err_q    <= err_d;
      cipher_q <= cipher_d;
      key_q    <= key_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = grant ? START : IDLE;
      START:   state_d = BUSY;
      BUSY:    state_d = done || tmo ? HOLD : BUSY;
      HOLD:    state_d = out_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end

  // a real completion in the timeout cycle wins over the abort
  always_comb begin
    last_d   = grant ? win : last_q;
    id_d     = grant ? win : id_q;
    cipher_d = grant ? (win ? req1_cipher : req0_cipher) : cipher_q;
    key_d    = grant ? (win ? req1_key10 : req0_key10) : key_q;
    first_d  = state_q == START;
    data_d   = done ? eng_plain_text : tmo ? '0 : data_q;
    err_d    = done ? 1'b0 : tmo ? 1'b1 : err_q;
  end

  always_comb begin
    req0_ready       = reset_n && grant && !win;
    req1_ready       = reset_n && grant && win;
    eng_new_en       = state_q == START;
    eng_cipher_text  = cipher_q;
    eng_round_key_10 = key_q;
    out_valid        = state_q == HOLD;
    out_data         = data_q;
    out_id           = id_q;
    out_err          = err_q;
  end
endmodule

// File: tb/tb_aes_decrypt_arbiter.sv
// tb_aes_decrypt_arbiter: randomized scoreboard bench with a stub decrypt engine.
module tb_aes_decrypt_arbiter;
  localparam logic [127:0] KAT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KAT_K = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] KAT_P = 128'h00112233445566778899aabbccddeeff;

  logic clk = 0, reset_n = 1;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [127:0] req0_cipher = 0, req1_cipher = 0, req0_key10 = 0, req1_key10 = 0;
  logic [127:0] eng_cipher_text, eng_round_key_10, out_data;
  logic eng_new_en, out_valid, out_id, out_err;
  logic eng_ready = 1, out_ready = 1;
  logic [127:0] eng_plain_text = 0;

  int checks = 0, errors = 0, cyc_n = 0;
  int n_granted = 0, n_done = 0;
  bit force_stale = 0, stuck = 0;
  logic g0, g1;

  typedef struct {logic id; logic [127:0] data; logic err; int gcyc;} exp_t;
  exp_t q[$];
  logic grants[$];

  aes_decrypt_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_cipher(req0_cipher), .req0_key10(req0_key10), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_cipher(req1_cipher), .req1_key10(req1_key10), .req1_ready(req1_ready),
    .eng_cipher_text(eng_cipher_text), .eng_round_key_10(eng_round_key_10), .eng_new_en(eng_new_en),
    .eng_ready(eng_ready), .eng_plain_text(eng_plain_text),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_err(out_err), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // stand-in engine: one known-answer vector, otherwise a keyed scramble
  function automatic logic [127:0] plain_of(input logic [127:0] c, input logic [127:0] k);
    if (c == KAT_C && k == KAT_K) return KAT_P;
    return c ^ {k[63:0], k[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h @%0t", name, act, exp, $time);
    end
  endtask

  // engine: may keep a stale eng_ready through START and the first BUSY cycle
  initial begin
    logic [127:0] c, k;
    int lat;
    bit st;
    forever begin
      @(negedge clk);
      if (reset_n && eng_new_en) begin
        c = eng_cipher_text;
        k = eng_round_key_10;
        lat = $urandom_range(0, 4);
        st = !stuck && (force_stale || $urandom_range(0, 1) == 1);
        if (!st) eng_ready = 0;
        @(negedge clk);
        @(negedge clk);
        eng_ready = 0;
        repeat (lat) @(negedge clk);
        while (stuck) @(negedge clk);
        eng_ready = 1;
        eng_plain_text = plain_of(c, k);
      end
    end
  end

  // reference model: one job in flight, round-robin on ties, no request buffering
  logic m_last = 1, m_start = 0;
  logic [127:0] m_c, m_k;
  always @(negedge clk) begin
    logic w;
    if (!reset_n) begin
      chk("rst_ctl", {req0_ready, req1_ready, eng_new_en, out_valid, out_id, out_err}, 0);
      chk("rst_eng_ct", eng_cipher_text, 0);
      chk("rst_eng_key", eng_round_key_10, 0);
      chk("rst_out_data", out_data, 0);
      n_granted = 0;
      m_last = 1;
      m_start = 0;
    end else begin
      chk("eng_new_en", eng_new_en, m_start);
      if (m_start) begin
        chk("eng_ct", eng_cipher_text, m_c);
        chk("eng_key", eng_round_key_10, m_k);
      end
      m_start = 0;
      if (n_granted == n_done && (req0_valid || req1_valid)) begin
        w = (req0_valid && req1_valid) ? !m_last : req1_valid;
        m_c = w ? req1_cipher : req0_cipher;
        m_k = w ? req1_key10 : req0_key10;
        chk("grant", {req1_ready, req0_ready}, w ? 2'b10 : 2'b01);
        q.push_back('{id: w, data: stuck ? 128'h0 : plain_of(m_c, m_k), err: stuck, gcyc: cyc_n});
        grants.push_back(w);
        m_last = w;
        m_start = 1;
        n_granted++;
      end else chk("no_grant", {req1_ready, req0_ready}, 0);
    end
  end

  // monitor: pops on each output handshake, checks hold stability under backpressure
  logic hp = 0, hi, he;
  logic [127:0] hd;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      q.delete();
      n_done <= 0;
      hp = 0;
    end else if (out_valid) begin
      if (hp) begin
        chk("hold_data", out_data, hd);
        chk("hold_id_err", {out_id, out_err}, {hi, he});
      end else if (q.size() == 0) chk("spurious_valid", out_valid, 0);
      if (!hp && q.size() != 0 && q[0].err) chk("timeout_latency", cyc_n - q[0].gcyc, 10);
      if (out_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_id", out_id, e.id);
        chk("out_err", out_err, e.err);
        n_done <= n_done + 1;
        hp = 0;
      end else begin
        hp = 1;
        hd = out_data;
        hi = out_id;
        he = out_err;
      end
    end else hp = 0;
  end

  task automatic cyc();
    @(negedge clk);
    g0 = req0_ready;
    g1 = req1_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic n, input logic [127:0] c, input logic [127:0] k);
    int t = 0;
    if (n) begin req1_valid = 1; req1_cipher = c; req1_key10 = k; end
    else begin req0_valid = 1; req0_cipher = c; req0_key10 = k; end
    do begin cyc(); t++; end while (!(n ? g1 : g0) && t < 100);
    chk("issue_wait", t < 100, 1);
    if (n) req1_valid = 0; else req0_valid = 0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || out_valid) && t < 300) begin cyc(); t++; end
    chk("drain_wait", t < 300, 1);
  endtask

  initial begin
    int t, jobs;
    logic [3:0] ord;
    #1 reset_n = 0;
    repeat (3) cyc();
    reset_n = 1;
    // contention from reset: expect 0,1,0,1
    req0_valid = 1; req0_cipher = rnd(); req0_key10 = rnd();
    req1_valid = 1; req1_cipher = rnd(); req1_key10 = rnd();
    t = 0; jobs = 0;
    while (jobs < 4 && t < 400) begin
      cyc(); t++;
      if (g0) begin req0_cipher = rnd(); req0_key10 = rnd(); jobs++; end
      if (g1) begin req1_cipher = rnd(); req1_key10 = rnd(); jobs++; end
    end
    req0_valid = 0; req1_valid = 0;
    drain();
    ord = 4'bxxxx;
    foreach (grants[i]) if (i < 4) ord[3-i] = grants[i];
    chk("rr_order", ord, 4'b0101);
    // known-answer job
    issue(0, KAT_C, KAT_K);
    drain();
    // backpressure with a competing request waiting
    out_ready = 0;
    issue(1, rnd(), rnd());
    t = 0;
    while (!out_valid && t < 50) begin cyc(); t++; end
    chk("hold_reached", out_valid, 1);
    req0_valid = 1; req0_cipher = rnd(); req0_key10 = rnd();
    repeat (10) cyc();
    out_ready = 1;
    t = 0;
    do begin cyc(); t++; end while (!g0 && t < 50);
    chk("post_hold_grant", g0, 1);
    req0_valid = 0;
    drain();
    // stale eng_ready from the previous job
    force_stale = 1;
    issue(0, rnd(), rnd());
    drain();
    force_stale = 0;
    // random traffic with drops and backpressure
    for (int i = 0; i < 400; i++) begin
      cyc();
      if (g0 || (!req0_valid && $urandom_range(0, 3) == 0)) begin
        req0_cipher = rnd(); req0_key10 = rnd(); req0_valid = g0 ? 1'($urandom_range(0, 1)) : 1'b1;
      end else if (req0_valid && $urandom_range(0, 19) == 0) req0_valid = 0;
      if (g1 || (!req1_valid && $urandom_range(0, 3) == 0)) begin
        req1_cipher = rnd(); req1_key10 = rnd(); req1_valid = g1 ? 1'($urandom_range(0, 1)) : 1'b1;
      end else if (req1_valid && $urandom_range(0, 19) == 0) req1_valid = 0;
      out_ready = $urandom_range(0, 3) != 0;
    end
    req0_valid = 0; req1_valid = 0; out_ready = 1;
    drain();
    // reset in the second BUSY cycle discards the job
    issue(0, rnd(), rnd());
    cyc(); cyc();
    reset_n = 0;
    cyc(); cyc();
    reset_n = 1;
    repeat (10) cyc();
    chk("post_rst_idle", {out_valid, eng_new_en}, 0);
    issue(1, rnd(), rnd());
    drain();
`ifdef AES_DEC_ARB_TIMEOUT_EN
    stuck = 1;
    issue(1, rnd(), rnd());
    drain();
    stuck = 0;
    repeat (10) cyc();
    issue(0, rnd(), rnd());
    drain();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule

// File: doc/aes_decrypt_arbiter.md
AES_DECRYPT_ARBITER -- requirements
Module: aes_decrypt_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, is the maximum cycles from engine start to the engine ready flag before abort; it is used only when AES_DEC_ARB_TIMEOUT_EN is defined.
REQ-002 The block SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 req0_valid, req1_valid  input  1 each  requester N has a job pending.
REQ-006 req0_cipher, req1_cipher  input  128 each  ciphertext for requester N.
REQ-007 req0_key10, req1_key10  input  128 each  round-10 key for requester N.
REQ-008 req0_ready, req1_ready  output  1 each  job from requester N accepted this cycle.
REQ-009 eng_cipher_text, eng_round_key_10  output  128 each  registered operands driven to the shared decrypt engine.
REQ-010 eng_new_en  output  1  single-cycle start pulse to the engine.
REQ-011 eng_ready  input  1  engine done flag (level).
REQ-012 eng_plain_text  input  128  engine result.
REQ-013 out_valid  output  1  result available.
REQ-014 out_data  output  128  registered plaintext.
REQ-015 out_id  output  1  requester that owns out_data.
REQ-016 out_err  output  1  result aborted by timeout (0 when the macro is undefined).
REQ-017 out_ready  input  1  consumer accepts the result.

Function
REQ-018 FSM states are IDLE, START, BUSY and HOLD.
- IDLE->START when any reqN_valid is high.
- START->BUSY unconditionally.
- BUSY->HOLD on done.
- HOLD->IDLE on out_valid&&out_ready.
REQ-019 Arbitration in IDLE is round-robin.
- The winner is the requester that did not win last; a single valid requester always wins.
- last_grant resets to 1, so requester 0 wins the first tie.
REQ-020 In the IDLE cycle of grant, the block SHALL pulse reqN_ready for the winner only, latch that requester's cipher and key10 into the eng_* registers, and record the id.
REQ-021 eng_new_en SHALL be high for exactly the START cycle and never at any other time.
REQ-022 eng_cipher_text and eng_round_key_10 SHALL hold stable from START until leaving BUSY.
REQ-023 eng_ready SHALL be ignored during START and the first BUSY cycle.
- done is the first subsequent BUSY cycle with eng_ready=1.
- On done, eng_plain_text is captured into out_data.
REQ-024 out_valid SHALL be high throughout HOLD, with out_data, out_id and out_err stable until the handshake completes.
REQ-025 New requests SHALL NOT be granted outside IDLE; reqN_ready SHALL be 0 in START, BUSY and HOLD.
REQ-026 A requester dropping reqN_valid before grant SHALL lose its request; no buffering is performed.
REQ-027 Minimum request-to-out_valid latency is 3 cycles plus the engine latency; one job is in flight at most.

Reset
REQ-028 While reset_n=0, the block SHALL be in IDLE with all outputs 0.
- All outputs: req*_ready, eng_new_en, eng_cipher_text, eng_round_key_10, out_valid, out_data, out_id, out_err.
- Internal state: last_grant=1, timeout counter=0.
REQ-029 Reset asserted mid-job SHALL discard the job without a result; after release, the engine is re-started only on a new grant.

Configuration
REQ-030 Macro AES_DEC_ARB_TIMEOUT_EN SHALL enable the watchdog; when it is undefined, the watchdog logic is absent and out_err is tied to 0.
- The counter clears in START and increments each BUSY cycle.
- If it reaches TIMEOUT_CYCLES without done: enter HOLD with out_err=1 and out_data=0.
- An engine completing in the same cycle as the timeout counts as done, with out_err=0.

Verification
REQ-031 Single job: req0 with cipher 69c4e0d86a7b0430d8cdb78070b4c55a and key10 13111d7fe3944a17f307a78b4d2b30c5 -> one eng_new_en pulse; then out_valid=1, out_data=00112233445566778899aabbccddeeff, out_id=0, out_err=0.
REQ-032 Contention: req0 and req1 held valid for 4 jobs -> grants in the order 0,1,0,1, each out_id matching the grant order.
REQ-033 Backpressure: out_ready=0 for 10 cycles in HOLD -> out_* stable, no reqN_ready pulse, no eng_new_en; the job completes on the first out_ready=1.
REQ-034 Stale ready: eng_ready held at 1 from the previous job -> ignored in START and the first BUSY cycle; no premature capture.
REQ-035 Reset mid-BUSY: reset_n=0 for 2 cycles -> all outputs 0 and no out_valid; a following req1 job completes correctly with out_id=1.
REQ-036 Timeout (macro defined, TIMEOUT_CYCLES=8, eng_ready stuck at 0): out_valid=1, out_err=1 and out_data=0 after 8 BUSY cycles, then return to IDLE.
